// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous memory between an instruction-fetch
//   port (read-only) and a load/store port. Each access takes two cycles:
//   ACC (memory strobe, grant to the winner) then RESP (read data / completion).
//   The load/store port has priority. A starvation counter forces a fetch win
//   once the LSU has won STARVE_LIMIT times in a row while fetch was waiting.
//
// Ports
//   clk, rstN                      clock, asynchronous active-low reset
//   ifReq/ifAddr/ifFlush           fetch request, address, branch-flush
//   ifGnt/ifValid/ifRdata          fetch accept, response strobe, fetched word
//   lsReq/lsWe/lsAddr/lsWdata      load/store request, store flag, address, data
//   lsGnt/lsValid/lsRdata          LSU accept, response strobe, loaded word
//   memEn/memWe/memAddr/memWdata   memory strobe, write enable, address, data
//   memRdata                       memory read data (valid the cycle after strobe)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  input  logic              ifFlush,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              lsReq,
  input  logic              lsWe,
  input  logic [ADDR_W-1:0] lsAddr,
  input  logic [DATA_W-1:0] lsWdata,
  output logic              lsGnt,
  output logic              lsValid,
  output logic [DATA_W-1:0] lsRdata,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        starve_cnt;
  logic              flush_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic arb;
  logic starved;
  logic if_win;
  logic ls_win;

  // Arbitration decision, only meaningful in IDLE and RESP.
  always_comb begin
    arb     = (state == IDLE) || (state == RESP);
    starved = (starve_cnt == LIMIT);
    if_win  = ifReq && (!lsReq || starved);
    ls_win  = lsReq && !if_win;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE, RESP: begin
        if (if_win || ls_win) begin
          state_nxt = ACC;
          owner_nxt = ls_win ? OWN_LS : OWN_IF;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC:     state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the state directly, so an asynchronous reset clears
  // grants, strobes and valids in the same instant it returns state to IDLE.
  // Read data is bypassed from memory during the valid cycle and otherwise
  // shows the last captured value.
  always_comb begin
    memEn    = (state == ACC);
    memWe    = (state == ACC) && we_q;
    memAddr  = addr_q;
    memWdata = wdata_q;
    ifGnt    = (state == ACC) && (owner == OWN_IF);
    lsGnt    = (state == ACC) && (owner == OWN_LS);
    ifValid  = (state == RESP) && (owner == OWN_IF) && !flush_q && !ifFlush;
    lsValid  = (state == RESP) && (owner == OWN_LS);
    ifRdata  = ifValid ? memRdata : if_rdata_q;
    lsRdata  = (lsValid && !we_q) ? memRdata : ls_rdata_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      flush_q    <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;

      if (arb) begin
        if (ls_win) begin
          addr_q  <= lsAddr;
          we_q    <= lsWe;
          wdata_q <= lsWdata;
        end else if (if_win) begin
          // Fetches never write; leave the write-data register untouched.
          addr_q <= ifAddr;
          we_q   <= 1'b0;
        end

        if (!ifReq || if_win) begin
          starve_cnt <= '0;
        end else if (ls_win && (starve_cnt != LIMIT)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end

      // A flush in ACC is remembered for RESP; a flush in RESP acts directly.
      flush_q <= (state == ACC) && ifFlush;

      if (ifValid) begin
        if_rdata_q <= memRdata;
      end
      if (lsValid && !we_q) begin
        ls_rdata_q <= memRdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed, table-driven bench for mem_port_arbiter (default parameters).
//   Inputs are applied on the falling edge; outputs of that same cycle are
//   sampled 1 time unit later. Multi-cycle idle and mid-access reset cases
//   are written out by hand after the table.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rstN;
  logic        ifReq;
  logic [7:0]  ifAddr;
  logic        ifFlush;
  logic        ifGnt;
  logic        ifValid;
  logic [15:0] ifRdata;
  logic        lsReq;
  logic        lsWe;
  logic [7:0]  lsAddr;
  logic [15:0] lsWdata;
  logic        lsGnt;
  logic        lsValid;
  logic [15:0] lsRdata;
  logic        memEn;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [15:0] memWdata;
  logic [15:0] memRdata;

  mem_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rstN(rstN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifFlush(ifFlush),
    .ifGnt(ifGnt), .ifValid(ifValid), .ifRdata(ifRdata),
    .lsReq(lsReq), .lsWe(lsWe), .lsAddr(lsAddr), .lsWdata(lsWdata),
    .lsGnt(lsGnt), .lsValid(lsValid), .lsRdata(lsRdata),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [7:0]  ia;
    logic        fl;
    logic        lsr;
    logic        lwe;
    logic [7:0]  la;
    logic [15:0] lwd;
    logic [15:0] mrd;
    logic        igt;
    logic        ivl;
    logic [15:0] ird;
    logic        lgt;
    logic        lvl;
    logic [15:0] lrd;
    logic        men;
    logic        mwe;
    logic [7:0]  ma;
    logic [15:0] mwd;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(
    input logic rst, input logic ifr, input logic [7:0] ia, input logic fl,
    input logic lsr, input logic lwe, input logic [7:0] la, input logic [15:0] lwd,
    input logic [15:0] mrd,
    input logic igt, input logic ivl, input logic [15:0] ird,
    input logic lgt, input logic lvl, input logic [15:0] lrd,
    input logic men, input logic mwe, input logic [7:0] ma, input logic [15:0] mwd);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ia = ia; v.fl = fl;
    v.lsr = lsr; v.lwe = lwe; v.la = la; v.lwd = lwd; v.mrd = mrd;
    v.igt = igt; v.ivl = ivl; v.ird = ird;
    v.lgt = lgt; v.lvl = lvl; v.lrd = lrd;
    v.men = men; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int unsigned step,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int unsigned step, input vec_t v);
    chk("ifGnt",    step, 16'(ifGnt),    16'(v.igt));
    chk("ifValid",  step, 16'(ifValid),  16'(v.ivl));
    chk("ifRdata",  step, ifRdata,       v.ird);
    chk("lsGnt",    step, 16'(lsGnt),    16'(v.lgt));
    chk("lsValid",  step, 16'(lsValid),  16'(v.lvl));
    chk("lsRdata",  step, lsRdata,       v.lrd);
    chk("memEn",    step, 16'(memEn),    16'(v.men));
    chk("memWe",    step, 16'(memWe),    16'(v.mwe));
    chk("memAddr",  step, 16'(memAddr),  16'(v.ma));
    chk("memWdata", step, memWdata,      v.mwd);
  endtask

  task automatic drive(input vec_t v);
    rstN     = v.rst;
    ifReq    = v.ifr;
    ifAddr   = v.ia;
    ifFlush  = v.fl;
    lsReq    = v.lsr;
    lsWe     = v.lwe;
    lsAddr   = v.la;
    lsWdata  = v.lwd;
    memRdata = v.mrd;
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rstN = 1'b0; ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
    lsReq = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0; memRdata = '0;

    //  rst ifr ia    fl lsr lwe la    lwd       mrd       | igt ivl ird       lgt lvl lrd       men mwe ma    mwd
    // reset, then single fetch
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000);
    add(1, 1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000);
    add(1, 1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 8'h10, 16'h0000);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'hABCD,  0, 1, 16'hABCD, 0, 0, 16'h0000, 0, 0, 8'h10, 16'h0000);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'h0000, 0, 0, 8'h10, 16'h0000);
    // store to 0x20, then back-to-back load from 0x20
    add(1, 0, 8'h00, 0, 1, 1, 8'h20, 16'h1234, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'h0000, 0, 0, 8'h10, 16'h0000);
    add(1, 0, 8'h00, 0, 1, 1, 8'h20, 16'h1234, 16'h0000,  0, 0, 16'hABCD, 1, 0, 16'h0000, 1, 1, 8'h20, 16'h1234);
    add(1, 0, 8'h00, 0, 1, 0, 8'h20, 16'h1234, 16'hFFFF,  0, 0, 16'hABCD, 0, 1, 16'h0000, 0, 0, 8'h20, 16'h1234);
    add(1, 0, 8'h00, 0, 1, 0, 8'h20, 16'h1234, 16'h0000,  0, 0, 16'hABCD, 1, 0, 16'h0000, 1, 0, 8'h20, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'hBEEF,  0, 0, 16'hABCD, 0, 1, 16'hBEEF, 0, 0, 8'h20, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h20, 16'h1234);
    // flush during fetch ACC
    add(1, 1, 8'h30, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h20, 16'h1234);
    add(1, 1, 8'h30, 1, 0, 0, 8'h00, 16'h0000, 16'h0000,  1, 0, 16'hABCD, 0, 0, 16'hBEEF, 1, 0, 8'h30, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h1111,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h30, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h30, 16'h1234);
    // flush during fetch RESP
    add(1, 1, 8'h40, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h30, 16'h1234);
    add(1, 1, 8'h40, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  1, 0, 16'hABCD, 0, 0, 16'hBEEF, 1, 0, 8'h40, 16'h1234);
    add(1, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0000, 16'h2222,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h40, 16'h1234);
    // flush while idle has no effect on the following fetch
    add(1, 1, 8'h44, 1, 0, 0, 8'h00, 16'h0000, 16'h0000,  0, 0, 16'hABCD, 0, 0, 16'hBEEF, 0, 0, 8'h40, 16'h1234);
    add(1, 1, 8'h44, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,  1, 0, 16'hABCD, 0, 0, 16'hBEEF, 1, 0, 8'h44, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h3333,  0, 1, 16'h3333, 0, 0, 16'hBEEF, 0, 0, 8'h44, 16'h1234);
    // contention: LS,LS,LS,LS then IF forced by starvation, then LS
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h3333, 0, 0, 16'hBEEF, 0, 0, 8'h44, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h3333, 1, 0, 16'hBEEF, 1, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0A01,  0, 0, 16'h3333, 0, 1, 16'h0A01, 0, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h3333, 1, 0, 16'h0A01, 1, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0A02,  0, 0, 16'h3333, 0, 1, 16'h0A02, 0, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h3333, 1, 0, 16'h0A02, 1, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0A03,  0, 0, 16'h3333, 0, 1, 16'h0A03, 0, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h3333, 1, 0, 16'h0A03, 1, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0A04,  0, 0, 16'h3333, 0, 1, 16'h0A04, 0, 0, 8'h60, 16'h1234);
    add(1, 1, 8'h50, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  1, 0, 16'h3333, 0, 0, 16'h0A04, 1, 0, 8'h50, 16'h1234);
    add(1, 0, 8'h00, 0, 1, 0, 8'h60, 16'h1234, 16'h0A05,  0, 1, 16'h0A05, 0, 0, 16'h0A04, 0, 0, 8'h50, 16'h1234);
    add(1, 0, 8'h00, 0, 1, 0, 8'h60, 16'h1234, 16'h0000,  0, 0, 16'h0A05, 1, 0, 16'h0A04, 1, 0, 8'h60, 16'h1234);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 16'h0A06,  0, 0, 16'h0A05, 0, 1, 16'h0A06, 0, 0, 8'h60, 16'h1234);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_all(i, vecs[i]);
    end

    // Idle for 10 cycles: no strobe, address register holds.
    v = vecs[vecs.size()-1];
    v.mrd = '0;
    drive(v);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memRdata = 16'($urandom_range(0, 16'hFFFF));
      #1;
      chk("idle_memEn",   100 + i, 16'(memEn),   16'h0000);
      chk("idle_memAddr", 100 + i, 16'(memAddr), 16'h0060);
      chk("idle_gnt",     100 + i, 16'({ifGnt, lsGnt}), 16'h0000);
    end

    // Reset asserted in the LS RESP cycle aborts the load.
    @(negedge clk);
    lsReq = 1'b1; lsWe = 1'b0; lsAddr = 8'h70; lsWdata = 16'h0000; memRdata = '0;
    #1;
    chk("rst_seq_idle_memEn", 200, 16'(memEn), 16'h0000);
    @(negedge clk);
    #1;
    chk("rst_seq_lsGnt", 201, 16'(lsGnt),   16'h0001);
    chk("rst_seq_addr",  201, 16'(memAddr), 16'h0070);
    @(negedge clk);
    lsReq = 1'b0; memRdata = 16'h5A5A;
    #1;
    chk("rst_seq_lsValid_pre", 202, 16'(lsValid), 16'h0001);
    rstN  = 1'b0;
    ifReq = 1'b1; ifAddr = 8'h80;
    #1;
    chk("rst_lsValid",  203, 16'(lsValid),  16'h0000);
    chk("rst_lsRdata",  203, lsRdata,       16'h0000);
    chk("rst_ifRdata",  203, ifRdata,       16'h0000);
    chk("rst_memAddr",  203, 16'(memAddr),  16'h0000);
    chk("rst_memWdata", 203, memWdata,      16'h0000);
    chk("rst_strobes",  203, 16'({ifGnt, lsGnt, ifValid, memEn, memWe}), 16'h0000);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("rel1_ifGnt", 204, 16'(ifGnt), 16'h0000);
    chk("rel1_memEn", 204, 16'(memEn), 16'h0000);
    @(negedge clk);
    #1;
    chk("rel2_ifGnt",   205, 16'(ifGnt),   16'h0001);
    chk("rel2_memEn",   205, 16'(memEn),   16'h0001);
    chk("rel2_memAddr", 205, 16'(memAddr), 16'h0080);
    ifReq = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive LSU wins tolerated while fetch waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstN  input  1  reset, asynchronous assert, active-low.
REQ-006 ifReq  input  1  instruction-fetch read request; held with ifAddr until ifGnt.
REQ-007 ifAddr  input  ADDR_W  fetch address.
REQ-008 ifFlush  input  1  branch taken; cancels the in-flight fetch response.
REQ-009 ifGnt  output  1  fetch request accepted this cycle.
REQ-010 ifValid  output  1  ifRdata valid, one-cycle pulse.
REQ-011 ifRdata  output  DATA_W  fetched word.
REQ-012 lsReq  input  1  load/store request; held with lsWe, lsAddr, lsWdata until lsGnt.
REQ-013 lsWe  input  1  1 = store, 0 = load.
REQ-014 lsAddr  input  ADDR_W  data address.
REQ-015 lsWdata  input  DATA_W  store data.
REQ-016 lsGnt  output  1  LSU request accepted this cycle.
REQ-017 lsValid  output  1  load data valid, or store completed; one-cycle pulse.
REQ-018 lsRdata  output  DATA_W  loaded word.
REQ-019 memEn  output  1  memory access strobe.
REQ-020 memWe  output  1  memory write enable, qualified by memEn.
REQ-021 memAddr  output  ADDR_W  memory address.
REQ-022 memWdata  output  DATA_W  memory write data.
REQ-023 memRdata  input  DATA_W  read data, valid the cycle after a read strobe.

Function
REQ-024 The FSM SHALL have three states: IDLE, ACC (memory strobe), RESP (response). It SHALL record the owner of ACC and RESP as IF or LS.
REQ-025 Arbitration SHALL occur in IDLE and in RESP. If any request is pending, the next state SHALL be ACC. Otherwise it SHALL be IDLE.
REQ-026 Arbitration priority SHALL be LS over IF, except when starveCnt == STARVE_LIMIT and ifReq=1, in which case IF SHALL win.
REQ-027 The winner's address, write enable, and write data SHALL be registered at the arbitration edge. In ACC these registers SHALL drive memAddr, memWe, and memWdata, with memEn=1. The winner's Gnt SHALL be 1 for exactly that ACC cycle.
REQ-028 The state after ACC SHALL always be RESP. Throughput SHALL be one access per 2 cycles under continuous requests.
REQ-029 In RESP with owner IF: ifValid=1 and ifRdata=memRdata, unless ifFlush was seen in ACC or RESP, in which case ifValid=0.
REQ-030 In RESP with owner LS: lsValid=1. For a load, lsRdata=memRdata. For a store, lsRdata SHALL hold its previous value.
REQ-031 ifRdata and lsRdata SHALL be registered and hold their value until the next valid response of the same port.
REQ-032 starveCnt (4 bits) SHALL increment when LS is granted while ifReq=1. It SHALL clear when IF is granted or when ifReq=0 at an arbitration point. It SHALL saturate at STARVE_LIMIT.
REQ-033 ifFlush while IF is in IDLE or not owning ACC/RESP SHALL have no effect. ifGnt is unaffected by ifFlush.
REQ-034 Outside ACC, memEn, memWe, ifGnt, and lsGnt SHALL be 0. memAddr and memWdata SHALL hold their last values.
REQ-035 A request dropped before its Gnt SHALL be ignored. The bus SHALL never be granted to a requester whose Req is 0 at the arbitration edge.

Reset
REQ-036 While rstN=0: state=IDLE, starveCnt=0, and all outputs (Gnt, Valid, memEn, memWe, memAddr, memWdata, ifRdata, lsRdata) SHALL be 0.
REQ-037 Reset asserted during ACC or RESP SHALL abort the access with no Valid pulse. The first grant is possible in the second cycle after rstN rises.

Verification
REQ-038 Single fetch: ifReq=1, ifAddr=0x10, memRdata=0xABCD -> ifGnt in cycle 1 with memEn=1, memAddr=0x10, memWe=0; ifValid in cycle 2 with ifRdata=0xABCD.
REQ-039 Store then load: lsWe=1, lsAddr=0x20, lsWdata=0x1234, then a load from 0x20 -> memWe=1 with memWdata=0x1234, lsValid pulse; then memWe=0 and lsValid with lsRdata=memRdata.
REQ-040 Contention: ifReq and lsReq both held high, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS..., with starveCnt going 1,2,3,4,0.
REQ-041 Flush: ifFlush=1 during the IF ACC cycle -> ifGnt=1, memEn=1, no ifValid, ifRdata unchanged.
REQ-042 Mid-access reset: rstN=0 during the LS RESP cycle -> lsValid=0 immediately, all outputs 0; after release, a pending ifReq is granted in the second cycle.
REQ-043 Idle: no requests for 10 cycles -> memEn=0 throughout and memAddr holds its last value.
